uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter that succeeds the fixed 8N1 single-byte transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises them back-to-back with no idle gap. Frame format is configurable: data width, parity mode and stop-bit count, with the baud divisor derived from the clock frequency. It sits between character-producing logic (button-driven counters, test pattern generators) and a PMOD `je` pin.

---
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO of words serialised back-to-back with configurable data/parity/stop bits.
// tx falls two clocks after an accept when idle; tx_ready drops only while the FIFO holds FIFO_DEPTH words.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 125_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic push, pop, bit_end, frame_end;

  assign tx_ready  = (fifo_count != FULL);
  assign push      = tx_valid && tx_ready;
  assign bit_end   = (baud_cnt == DIV_LAST);
  assign frame_end = (state == S_STOP) && bit_end && (stop_idx == STOP_LAST);
  // Popping on the last stop clock is what makes consecutive frames gapless.
  assign pop       = (fifo_count != '0) && ((state == S_IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      // tx and busy trail the state by one clock, so every bit still lasts DIV clocks.
      busy <= (state != S_IDLE) || (fifo_count != '0);
      case (state)
        S_START: tx <= 1'b0;
        S_DATA:  tx <= shreg[0];
        S_PAR:   tx <= par_bit;
        default: tx <= 1'b1;
      endcase

      if (pop) begin
        shreg    <= mem[rd_ptr];
        par_bit  <= (PARITY == 1) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        baud_cnt <= '0;
        state    <= S_START;
      end else if (state != S_IDLE) begin
        if (!bit_end) begin
          baud_cnt <= baud_cnt + 1'b1;
        end else begin
          baud_cnt <= '0;
          case (state)
            S_START: state <= S_DATA;
            S_DATA: begin
              shreg <= {1'b0, shreg[DATA_BITS-1:1]};
              if (bit_idx == BIT_LAST) begin
                state <= (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
            S_PAR:  state <= S_STOP;
            S_STOP: begin
              if (frame_end) state <= S_IDLE;
              else           stop_idx <= 1'b1;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame configurations driven with random and directed words,
// decoded at bit centres and checked against an expected-frame scoreboard.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    int         pe;
  } exp_t;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : ch
    localparam int CLKF  = 1_000_000;
    localparam int BR    = (g == 0) ? 100_000 : (g == 1) ? 150_000 : 333_333;
    localparam int DB    = (g == 2) ? 7 : 8;
    localparam int PM    = (g == 0) ? 0 : (g == 1) ? 2 : 1;
    localparam int SB    = (g == 2) ? 2 : 1;
    localparam int DEP   = (g == 0) ? 16 : 4;
    localparam int DIV   = (CLKF + BR / 2) / BR;
    localparam int NB    = 1 + DB + ((PM != 0) ? 1 : 0) + SB;
    localparam int FRAME = NB * DIV;
    localparam int CNTW  = $clog2(DEP) + 1;
    localparam logic [7:0] MASK = 8'((1 << DB) - 1);

    logic            rst_n    = 1'b0;
    logic            tx_valid = 1'b0;
    logic [DB-1:0]   tx_data  = '0;
    logic            tx_ready, tx, busy;
    logic [CNTW-1:0] fifo_count;
    bit              fin      = 1'b0;
    bit              saw_full = 1'b0;
    exp_t            q[$];

    uart_tx_fifo #(
      .CLK_HZ(CLKF), .BAUD(BR), .DATA_BITS(DB), .PARITY(PM),
      .STOP_BITS(SB), .FIFO_DEPTH(DEP)
    ) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    function automatic string nm(input string s);
      return $sformatf("ch%0d_%s", g, s);
    endfunction

    // Line image of a frame: start, data LSB first, optional parity, stop bits; unused bits high.
    function automatic logic [11:0] frame_bits(input logic [7:0] d);
      logic [11:0] b;
      b    = '1;
      b[0] = 1'b0;
      for (int i = 0; i < DB; i++) b[1 + i] = d[i];
      if (PM != 0) b[1 + DB] = (^(d & MASK)) ^ (PM == 1);
      return b;
    endfunction

    task automatic send(input logic [7:0] d);
      bit r;
      int n;
      n        = 0;
      tx_valid = 1'b1;
      tx_data  = d[DB-1:0];
      do begin
        r = tx_ready;
        if (!r) begin
          saw_full = 1'b1;
          chk(fifo_count == DEP, nm("full_count"), int'(fifo_count), DEP);
        end
        @(negedge clk);
        n++;
      end while (!r && n < 4 * DEP * FRAME);
      if (!r) chk(1'b0, nm("push_timeout"), n, 0);
      else    q.push_back('{d & MASK, cyc});
    endtask

    task automatic idle_wait();
      int n;
      n = 0;
      repeat (2) @(negedge clk);
      while (busy !== 1'b0 && n < (DEP + 3) * FRAME + 20) begin
        @(negedge clk);
        n++;
      end
      chk(busy === 1'b0, nm("drain_timeout"), n, 0);
      chk(q.size() == 0, nm("scoreboard_empty"), q.size(), 0);
    endtask

    initial begin : mon
      bit          in_f, bogus;
      int          fs, last, want, off;
      logic [11:0] expb, rxb;
      exp_t        e;
      in_f = 1'b0;
      last = -1000000;
      expb = '1;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          q.delete();
          in_f = 1'b0;
          last = -1000000;
        end else if (!in_f) begin
          if (tx === 1'b0) begin
            in_f  = 1'b1;
            fs    = cyc;
            rxb   = '1;
            bogus = (q.size() == 0);
            if (bogus) begin
              chk(1'b0, nm("unexpected_frame"), fs, 0);
            end else begin
              e    = q.pop_front();
              want = (e.pe + 2 > last + FRAME) ? e.pe + 2 : last + FRAME;
              chk(fs == want, nm("start_time"), fs, want);
              expb = frame_bits(e.d);
            end
            last = fs;
          end
        end else begin
          off = cyc - fs;
          if (off % DIV == DIV / 2) rxb[off / DIV] = tx;
          if (off == FRAME - 1) begin
            in_f = 1'b0;
            if (!bogus) chk(rxb === expb, nm("frame_bits"), int'(rxb), int'(expb));
          end
        end
      end
    end

    initial begin : drv
      int seen, gap, e0, target;
      repeat (5) @(negedge clk);
      chk(tx === 1'b1, nm("rst_tx"), int'(tx), 1);
      chk(busy === 1'b0, nm("rst_busy"), int'(busy), 0);
      chk(fifo_count == 0, nm("rst_count"), int'(fifo_count), 0);
      chk(tx_ready === 1'b1, nm("rst_ready"), int'(tx_ready), 1);
      rst_n = 1'b1;
      seen  = 0;
      repeat (20) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) seen++;
      end
      chk(seen == 0, nm("idle_line"), seen, 0);

      send((g == 2) ? 8'h7E : 8'h41);
      tx_valid = 1'b0;
      chk(busy === 1'b0, nm("busy_at_accept"), int'(busy), 0);
      @(negedge clk);
      chk(busy === 1'b1 && tx === 1'b1, nm("busy_after_1"), int'({busy, tx}), 3);
      @(negedge clk);
      chk(tx === 1'b0, nm("start_after_2"), int'(tx), 0);
      idle_wait();

      saw_full = 1'b0;
      for (int i = 0; i < DEP + 5; i++) send((g == 0) ? 8'(i) : 8'($urandom));
      tx_valid = 1'b0;
      chk(saw_full, nm("ready_dropped"), int'(saw_full), 1);
      idle_wait();

      for (int i = 0; i < 25; i++) begin
        gap = $urandom_range(0, 2 * FRAME);
        if (gap > 0) tx_valid = 1'b0;
        repeat (gap) begin
          @(negedge clk);
          tx_data = DB'($urandom);
        end
        send(8'($urandom));
      end
      tx_valid = 1'b0;
      idle_wait();

      send(8'h00);
      e0 = cyc;
      for (int i = 0; i < 4; i++) send(8'h00);
      tx_valid = 1'b0;
      target   = e0 + 2 + 3 * DIV + DIV / 2;
      while (cyc < target) @(negedge clk);
      chk(fifo_count == 4, nm("queued_before_reset"), int'(fifo_count), 4);
      chk(tx === 1'b0, nm("low_before_reset"), int'(tx), 0);
      #1 rst_n = 1'b0;
      #1;
      chk(tx === 1'b1, nm("reset_tx_async"), int'(tx), 1);
      chk(fifo_count == 0, nm("reset_count_async"), int'(fifo_count), 0);
      chk(busy === 1'b0 && tx_ready === 1'b1, nm("reset_busy_ready"), int'({busy, tx_ready}), 1);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      repeat (3 * FRAME) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) seen++;
      end
      chk(seen == 0, nm("silent_after_reset"), seen, 0);

      send(8'($urandom));
      tx_valid = 1'b0;
      idle_wait();
      fin = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(ch[0].fin && ch[1].fin && ch[2].fin) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (!(ch[0].fin && ch[1].fin && ch[2].fin)) begin
      checks++;
      failures++;
      $display("FAIL global_timeout: got %0d cycles, required completion", n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
